bp_update_scheduler: RTL
========================

Name: bp_update_scheduler

Overview:
- Sits between the commit stage and the 3-port branch predictor update interface.
- Accepts up to 3 resolved-branch updates per cycle and buffers them in a circular FIFO.
- Issues them in order to the predictor's three update ports, never issuing two updates that target the same predictor index in one cycle. The predictor applies same-cycle same-index writes as last-write-wins, which loses counter steps, so such updates are deferred to a later cycle.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥4.
- INDEX_WIDTH, 5, predictor index width; index = pc[INDEX_WIDTH+1:2], matching the predictor.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- commit_valid_i_0/1/2  in  1 each  update request, lanes 0..2.
- commit_pc_0/1/2  in  ADDR_WIDTH each  branch PC.
- commit_mispred_0/1/2  in  1 each  misprediction flag.
- in_ready_o  out  1  all lanes accepted this cycle.
- update_prediction_valid_o_0/1/2  out  1 each  to predictor update_prediction_valid_i_n.
- update_prediction_pc_o_0/1/2  out  ADDR_WIDTH each  to predictor update_prediction_pc_n.
- misprediction_o_0/1/2  out  1 each  to predictor misprediction_n.
- occupancy_o  out  $clog2(DEPTH)+1  current entry count.
- defer_cnt_o  out  16  saturating count of conflict-deferral cycles.

Behaviour:
- Entry fields: {pc, mispred}.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- in_ready_o = (DEPTH − count ≥ 3). It is combinational from registered count only; there is no path from the commit inputs to in_ready_o.
- Enqueue:
  - When in_ready_o=1, the valid lanes are compacted in lane order (0,1,2) and written at tail, tail+1, tail+2. Tail advances by the number of valid lanes.
  - When in_ready_o=0, all commit inputs are ignored. Upstream must hold its requests.
- Issue (combinational from registered FIFO state), with candidates c0=head, c1=head+1, c2=head+2, each present only if its offset < count:
  - Lane 0 issues c0 if present.
  - Lane 1 issues c1 if lane 0 issued, c1 is present, and idx(c1)≠idx(c0).
  - Lane 2 issues c2 if lane 1 issued, c2 is present, and idx(c2)∉{idx(c0), idx(c1)}.
  - Issue is strictly in order: the first conflict stops issue for that cycle.
  - Non-issued lanes drive valid=0, pc=0, mispred=0.
- Pop: head advances by the number of lanes issued, at the same edge the predictor samples.
- Count: count_next = count + pushed − popped. Simultaneous push and pop are always legal, because ready is computed from the pre-pop count.
- Latency: an update accepted at edge N appears on the outputs in cycle N+1 at the earliest. There is no input-to-output bypass.
- defer_cnt_o: increments by 1 in each cycle where at least 2 entries are present and issued < min(count,3) because of an index conflict. It saturates at 16'hFFFF.
- Reset: asynchronous, active-low. It clears head, tail, count and defer_cnt_o immediately, so all update valids are 0, all pc/mispred outputs are 0, in_ready_o=1 and occupancy_o=0. Contents of buffered entries are discarded even if reset asserts mid-operation.
- FIFO storage needs no reset; outputs are gated by count.

Decomposition:
- Package bp_sched_pkg holds:
  - typedef bp_update_entry_t {pc, mispred};
  - localparam NUM_LANES=3;
  - function bp_index(pc) returning pc[INDEX_WIDTH+1:2].
- Sub-module bp_update_fifo: a 3-wide-push, 3-wide-pop circular buffer exposing count and the three head entries.
- The top level owns the conflict check, the issue decision and defer_cnt.

Test Plan:
- Reset with count=5 mid-run → all outputs 0 asynchronously, in_ready_o=1, occupancy_o=0; after release, no stale issues.
- Lane 0 only, pc=0x100, mispred=1, at cycle 0 → cycle 1: valid_o_0=1, pc_o_0=0x100, misprediction_o_0=1; cycle 2: all valids 0.
- Lanes 0..2 with pcs 0x100/0x104/0x108 (distinct indices) → next cycle all three lanes valid in order; occupancy returns to 0.
- Lanes 0..2 with pcs 0x100/0x180/0x104, where 0x100 and 0x180 share index 0:
  - cycle 1: only lane 0 (0x100) issues;
  - cycle 2: lane 0=0x180, lane 1=0x104;
  - defer_cnt_o=1.
- Backpressure: DEPTH=8, 3 same-index pushes per cycle, so 1 pop per cycle:
  - occupancy sequence is 3, 5, 7;
  - in_ready_o=0 at count 7; inputs during that cycle are ignored;
  - in_ready_o returns to 1 at count 5;
  - no entry is lost or duplicated.
- Sparse lanes: valid on lanes 0 and 2 only (pcs 0x200, 0x208) → next cycle issued on output lanes 0 and 1; lane 2 valid=0.

Source files
------------

// File: rtl/bp_sched_pkg.sv
// Shared types and helpers for the branch predictor update scheduler.
package bp_sched_pkg;

    localparam int unsigned NUM_LANES = 3;

    // One buffered predictor update, at the default 32-bit PC width.
    typedef struct packed {
        logic [31:0] pc;
        logic        mispred;
    } bp_update_entry_t;

    // Predictor table index: pc[index_width+1:2], matching the predictor's own hashing.
    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned index_width);
        logic [63:0] mask;
        mask = (64'd1 << index_width) - 64'd1;
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Circular buffer with up to 3 pushes and 3 pops per cycle; exposes the three
// oldest entries so the issue logic can inspect them without a read latency.
module bp_update_fifo
    import bp_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             push_cnt,
    input  logic [W-1:0]           push_data [NUM_LANES],
    input  logic [1:0]             pop_cnt,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head_data [NUM_LANES]
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [W-1:0]  mem [DEPTH];

    // Storage write: compacted push data lands at tail, tail+1, tail+2.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (i < 32'(push_cnt)) begin
                mem[tail + PW'(i)] <= push_data[i];
            end
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_cnt);
            tail  <= tail + PW'(push_cnt);
            count <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // Head window read: the three oldest slots, validity is judged by count.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            head_data[i] = mem[head + PW'(i)];
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Buffers up to 3 resolved branches per cycle and issues them in order to the
// 3-port predictor update interface, never sending two updates for the same
// predictor index in one cycle.
module bp_update_scheduler
    import bp_sched_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    commit_valid_i_0,
    input  logic                    commit_valid_i_1,
    input  logic                    commit_valid_i_2,
    input  logic [ADDR_WIDTH-1:0]   commit_pc_0,
    input  logic [ADDR_WIDTH-1:0]   commit_pc_1,
    input  logic [ADDR_WIDTH-1:0]   commit_pc_2,
    input  logic                    commit_mispred_0,
    input  logic                    commit_mispred_1,
    input  logic                    commit_mispred_2,
    output logic                    in_ready_o,
    output logic                    update_prediction_valid_o_0,
    output logic                    update_prediction_valid_o_1,
    output logic                    update_prediction_valid_o_2,
    output logic [ADDR_WIDTH-1:0]   update_prediction_pc_o_0,
    output logic [ADDR_WIDTH-1:0]   update_prediction_pc_o_1,
    output logic [ADDR_WIDTH-1:0]   update_prediction_pc_o_2,
    output logic                    misprediction_o_0,
    output logic                    misprediction_o_1,
    output logic                    misprediction_o_2,
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic [15:0]             defer_cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned W  = ADDR_WIDTH + 1;

    logic [NUM_LANES-1:0]  lane_v;
    logic [ADDR_WIDTH-1:0] lane_pc [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_mp;
    logic [W-1:0]          push_data [NUM_LANES];
    logic [1:0]            n_valid;
    logic [1:0]            push_cnt;
    logic [1:0]            pop_cnt;
    logic [CW-1:0]         count;
    logic [W-1:0]          head_data [NUM_LANES];
    logic [ADDR_WIDTH-1:0] head_pc [NUM_LANES];
    logic [63:0]           head_idx [NUM_LANES];
    logic [NUM_LANES-1:0]  present;
    logic [NUM_LANES-1:0]  iss;
    logic [1:0]            avail;
    logic                  defer_hit;

    assign lane_v     = {commit_valid_i_2, commit_valid_i_1, commit_valid_i_0};
    assign lane_pc[0] = commit_pc_0;
    assign lane_pc[1] = commit_pc_1;
    assign lane_pc[2] = commit_pc_2;
    assign lane_mp    = {commit_mispred_2, commit_mispred_1, commit_mispred_0};

    // Ready depends only on the registered count, so it never sees the commit inputs.
    assign in_ready_o = (count <= CW'(DEPTH - NUM_LANES));

    // Compact valid commit lanes in lane order so they occupy consecutive slots.
    always_comb begin
        n_valid = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            push_data[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_v[i]) begin
                push_data[n_valid] = {lane_pc[i], lane_mp[i]};
                n_valid            = n_valid + 2'd1;
            end
        end
        push_cnt = in_ready_o ? n_valid : 2'd0;
    end

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .count     (count),
        .head_data (head_data)
    );

    // In-order issue: each lane needs the previous lane issued and an index
    // distinct from every earlier candidate; the first conflict ends the cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            head_pc[i]  = head_data[i][W-1:1];
            head_idx[i] = bp_index(64'(head_pc[i]), INDEX_WIDTH);
            present[i]  = (32'(count) > i);
        end
        iss[0]    = present[0];
        iss[1]    = iss[0] && present[1] && (head_idx[1] != head_idx[0]);
        iss[2]    = iss[1] && present[2] && (head_idx[2] != head_idx[0])
                                          && (head_idx[2] != head_idx[1]);
        pop_cnt   = 2'(iss[0]) + 2'(iss[1]) + 2'(iss[2]);
        avail     = (count >= CW'(3)) ? 2'd3 : count[1:0];
        defer_hit = (count >= CW'(2)) && (pop_cnt < avail);
    end

    // Saturating count of cycles that lost issue bandwidth to an index conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            defer_cnt_o <= '0;
        end else if (defer_hit && (defer_cnt_o != 16'hFFFF)) begin
            defer_cnt_o <= defer_cnt_o + 16'd1;
        end
    end

    assign occupancy_o                 = count;
    assign update_prediction_valid_o_0 = iss[0];
    assign update_prediction_valid_o_1 = iss[1];
    assign update_prediction_valid_o_2 = iss[2];
    assign update_prediction_pc_o_0    = iss[0] ? head_pc[0] : '0;
    assign update_prediction_pc_o_1    = iss[1] ? head_pc[1] : '0;
    assign update_prediction_pc_o_2    = iss[2] ? head_pc[2] : '0;
    assign misprediction_o_0           = iss[0] & head_data[0][0];
    assign misprediction_o_1           = iss[1] & head_data[1][0];
    assign misprediction_o_2           = iss[2] & head_data[2][0];

endmodule
